fc_func_ctrl: RTL and testbench

Function-unit controller on the output side of a fully-connected CIM layer. It answers the layer controller's function-start/function-ready handshake. On each start it reads the signed partial sums of every output neuron from all vertical CIM tiles, adds them, and applies ReLU, an arithmetic right-shift requantisation and saturation. It writes the DATA_SIZE-bit results into the next layer's input buffer, then raises a one-cycle start toward the next layer.

---
 rtl/fc_func_ctrl.sv | 144 ++++++++++++++
 tb/tb_fc_func_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fc_func_ctrl.sv
// Output-side function unit for a fully-connected CIM layer: sums per-tile partial
// sums, applies ReLU, shift requantisation and saturation, then starts the next layer.
module fc_func_ctrl #(
  parameter int DATA_SIZE   = 8,
  parameter int XBAR_SIZE   = 128,
  parameter int V_CIM_TILES = 7,
  parameter int OUT_NEURONS = 128,
  parameter int PSUM_WIDTH  = 2*DATA_SIZE+$clog2(XBAR_SIZE),
  parameter int SHIFT       = 8,
  parameter int ADDR_WIDTH  = (OUT_NEURONS<=1)?1:$clog2(OUT_NEURONS),
  parameter int SUM_WIDTH   = PSUM_WIDTH+$clog2(V_CIM_TILES)+1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  output logic                              o_ready,
  output logic                              o_rd_en,
  output logic [ADDR_WIDTH-1:0]             o_rd_addr,
  input  logic [V_CIM_TILES*PSUM_WIDTH-1:0] i_psum,
  output logic                              o_wr_en,
  output logic [ADDR_WIDTH-1:0]             o_wr_addr,
  output logic [DATA_SIZE-1:0]              o_wr_data,
  input  logic                              i_next_ready,
  output logic                              o_next_start
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_DRAIN  = 2'd2,
    S_NOTIFY = 2'd3
  } state_t;

  localparam int EXT_W = SUM_WIDTH - PSUM_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUT_NEURONS - 1);
  localparam logic [SUM_WIDTH-1:0]  MAX_Q     = SUM_WIDTH'((1 << DATA_SIZE) - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [ADDR_WIDTH-1:0]   w_cnt_nxt;
  logic                    r_drain;
  logic                    w_drain_nxt;
  logic                    r_v1;
  logic [ADDR_WIDTH-1:0]   r_a1;
  logic                    r_wr_en;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [DATA_SIZE-1:0]    r_wr_data;
  logic signed [SUM_WIDTH-1:0] w_sum;
  logic [SUM_WIDTH-1:0]    w_shift;
  logic [DATA_SIZE-1:0]    w_act;
  logic                    w_rd_en;

  assign w_rd_en      = (r_state == S_READ);
  assign o_ready      = (r_state == S_IDLE);
  assign o_rd_en      = w_rd_en;
  assign o_rd_addr    = w_rd_en ? r_cnt : {ADDR_WIDTH{1'b0}};
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_next_start = (r_state == S_NOTIFY) && i_next_ready;

  // Sequencing: read sweep, two-cycle drain for the pipeline, then wait on the next layer
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drain_nxt = r_drain;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_READ;
          w_cnt_nxt   = {ADDR_WIDTH{1'b0}};
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (r_drain) begin
          w_state_nxt = S_NOTIFY;
        end else begin
          w_drain_nxt = 1'b1;
        end
      end
      S_NOTIFY: begin
        if (i_next_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_NOTIFY;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Tile reduction, ReLU, requantising shift and clamp to the activation range
  always_comb begin
    w_sum = {SUM_WIDTH{1'b0}};
    for (int t = 0; t < V_CIM_TILES; t++) begin
      w_sum = w_sum + {{EXT_W{i_psum[t*PSUM_WIDTH+PSUM_WIDTH-1]}}, i_psum[t*PSUM_WIDTH +: PSUM_WIDTH]};
    end
    w_shift = w_sum >>> SHIFT;
    if (w_sum[SUM_WIDTH-1]) begin
      w_act = {DATA_SIZE{1'b0}};
    end else if (w_shift > MAX_Q) begin
      w_act = {DATA_SIZE{1'b1}};
    end else begin
      w_act = w_shift[DATA_SIZE-1:0];
    end
  end

  // State, counters and the two pipeline stages
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= {ADDR_WIDTH{1'b0}};
      r_drain   <= 1'b0;
      r_v1      <= 1'b0;
      r_a1      <= {ADDR_WIDTH{1'b0}};
      r_wr_en   <= 1'b0;
      r_wr_addr <= {ADDR_WIDTH{1'b0}};
      r_wr_data <= {DATA_SIZE{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_drain   <= w_drain_nxt;
      r_v1      <= w_rd_en;
      r_a1      <= r_cnt;
      r_wr_en   <= r_v1;
      r_wr_addr <= r_v1 ? r_a1 : {ADDR_WIDTH{1'b0}};
      r_wr_data <= r_v1 ? w_act : {DATA_SIZE{1'b0}};
    end
  end

endmodule

// File: tb/tb_fc_func_ctrl.sv
// Randomised self-checking bench for fc_func_ctrl against a timeline reference model.
module tb_fc_func_ctrl;

  localparam int DS = 8;
  localparam int XB = 128;
  localparam int V  = 3;
  localparam int N  = 8;
  localparam int SH = 2;
  localparam int PW = 2*DS + $clog2(XB);
  localparam int AW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic              o_ready;
  logic              o_rd_en;
  logic [AW-1:0]     o_rd_addr;
  logic [V*PW-1:0]   i_psum;
  logic              o_wr_en;
  logic [AW-1:0]     o_wr_addr;
  logic [DS-1:0]     o_wr_data;
  logic              i_next_ready;
  logic              o_next_start;

  int n_vec = 0;
  int n_err = 0;
  int tbl [N][V];

  fc_func_ctrl #(
    .DATA_SIZE(DS), .XBAR_SIZE(XB), .V_CIM_TILES(V), .OUT_NEURONS(N), .SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_ready(o_ready),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_psum(i_psum),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .i_next_ready(i_next_ready), .o_next_start(o_next_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: sum the tiles, clip negatives, divide by 2^SH, clamp to 2^DS-1
  function automatic int ref_act(input int k);
    longint s = 0;
    for (int t = 0; t < V; t++) s += tbl[k][t];
    if (s < 0) return 0;
    s = s / (longint'(1) << SH);
    if (s > (1 << DS) - 1) return (1 << DS) - 1;
    return int'(s);
  endfunction

  task automatic drive_psum(input int k);
    logic [95:0]     g;
    logic [V*PW-1:0] v;
    g = {$urandom, $urandom, $urandom};
    v = g[V*PW-1:0];
    if (k >= 0) begin
      for (int t = 0; t < V; t++) v[t*PW +: PW] = PW'(tbl[k][t]);
    end
    i_psum = v;
  endtask

  function automatic int rnd_psum();
    case ($urandom_range(0, 7))
      0: return -(1 << (PW-1));
      1: return (1 << (PW-1)) - 1;
      default: return int'($urandom_range(0, 1200)) - 600;
    endcase
  endfunction

  task automatic fill_random();
    for (int k = 0; k < N; k++)
      for (int t = 0; t < V; t++) tbl[k][t] = rnd_psum();
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"},  int'(o_ready), 1);
    check_eq({tag, "_rd_en"},  int'(o_rd_en), 0);
    check_eq({tag, "_wr_en"},  int'(o_wr_en), 0);
    check_eq({tag, "_nstart"}, int'(o_next_start), 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0; i_start = 1'b0; i_next_ready = 1'($urandom_range(0, 1));
      drive_psum(-1);
      #1;
      check_idle("idle");
      check_eq("idle_rd_addr", int'(o_rd_addr), 0);
      check_eq("idle_wr_addr", int'(o_wr_addr), 0);
      check_eq("idle_wr_data", int'(o_wr_data), 0);
    end
  endtask

  // One operation on the spec timeline; cycle c=0 is the first cycle after accept
  task automatic run_op(input int wait_cyc, input bit hold, input int rst_at);
    int ns_cyc;
    ns_cyc = N + 2 + wait_cyc;
    @(negedge clk);
    rst = 1'b0; i_start = 1'b1; i_next_ready = 1'($urandom_range(0, 1));
    drive_psum(-1);
    #1;
    check_eq("accept_ready", int'(o_ready), 1);
    for (int c = 0; c < N + 40; c++) begin
      @(negedge clk);
      if (rst_at >= 0 && c >= rst_at) i_start = 1'b0;
      else i_start = (hold || c == 2 || c == N + 3) ? 1'b1 : 1'b0;
      drive_psum((c >= 1 && c <= N) ? c - 1 : -1);
      i_next_ready = (c >= ns_cyc) ? 1'b1 : 1'b0;
      rst = (c == rst_at) ? 1'b1 : 1'b0;
      #1;
      if (rst_at >= 0 && c > rst_at) begin
        check_idle("post_rst");
        if (c == rst_at + 3) break;
      end else begin
        check_eq("busy_ready", int'(o_ready), 0);
        check_eq("rd_en", int'(o_rd_en), (c < N) ? 1 : 0);
        if (c < N) check_eq("rd_addr", int'(o_rd_addr), c);
        check_eq("wr_en", int'(o_wr_en), (c >= 2 && c < N + 2) ? 1 : 0);
        if (c >= 2 && c < N + 2) begin
          check_eq("wr_addr", int'(o_wr_addr), c - 2);
          check_eq("wr_data", int'(o_wr_data), ref_act(c - 2));
        end
        check_eq("next_start", int'(o_next_start), (c == ns_cyc) ? 1 : 0);
        if (c == ns_cyc) break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_next_ready = 1'b0; i_psum = '0;
    repeat (2) @(posedge clk);
    idle_cycles(2);

    // Boundary values: shift rounding, saturation edge, ReLU, extremes
    tbl[0] = '{500, 300, 200};
    tbl[1] = '{1023, 0, 0};
    tbl[2] = '{1024, 0, 0};
    tbl[3] = '{-10, 4, 0};
    tbl[4] = '{3, 3, 0};
    tbl[5] = '{(1 << (PW-1)) - 1, (1 << (PW-1)) - 1, (1 << (PW-1)) - 1};
    tbl[6] = '{-(1 << (PW-1)), -(1 << (PW-1)), -(1 << (PW-1))};
    tbl[7] = '{200, 200, 0};
    run_op(0, 1'b0, -1);
    idle_cycles(2);

    fill_random();
    run_op(5, 1'b0, -1);
    idle_cycles(1);

    fill_random();
    run_op(0, 1'b0, 4);
    fill_random();
    run_op(0, 1'b0, -1);
    idle_cycles(1);

    fill_random();
    run_op(0, 1'b1, -1);
    fill_random();
    run_op(0, 1'b1, -1);
    idle_cycles(2);

    for (int i = 0; i < 6; i++) begin
      fill_random();
      run_op(int'($urandom_range(0, 3)), 1'b0, -1);
      idle_cycles(int'($urandom_range(1, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
